mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 61 ++++++
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundles the core, host and memory signals of the
//               two-port memory arbiter.
//               slave  - arbiter side: takes requests and mem_rdata, drives
//                        grants, read returns and the memory command.
//               master - environment side: drives requests and mem_rdata.
//               Ports:
//                 core: core_req/we/addr/wdata  -> arbiter
//                       core_gnt/rvalid/rdata   <- arbiter
//                 host: host_req/we/lock/addr/wdata -> arbiter
//                       host_gnt/rvalid/rdata       <- arbiter
//                 mem : mem_en/we/addr/wdata <- arbiter
//                       mem_rdata            -> arbiter
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
  // core requester
  logic       core_req;
  logic       core_we;
  logic [7:0] core_addr;
  logic [7:0] core_wdata;
  logic       core_gnt;
  logic       core_rvalid;
  logic [7:0] core_rdata;
  // host requester
  logic       host_req;
  logic       host_we;
  logic       host_lock;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic       host_rvalid;
  logic [7:0] host_rdata;
  // memory side
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  host_req, host_we, host_lock, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output host_req, host_we, host_lock, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates a single-ported synchronous memory between a core
//               and a host requester. Round-robin by default; the host may
//               lock the port for up to MAX_BURST consecutive grants while the
//               core waits.
//               Ports:
//                 clock - system clock
//                 reset - synchronous, active-high
//                 bus   - mem_port_arbiter_if.slave (core, host, memory)
//               Sequence per transaction:
//                 IDLE   : arbitrate, capture winner's command
//                 ACCESS : gnt pulse, memory command driven
//                 RDATA  : (reads only) owner's rvalid with mem_rdata
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int MAX_BURST = 16
) (
  input  wire logic           clock,
  input  wire logic           reset,
  mem_port_arbiter_if.slave   bus
);

  localparam int c_cnt_w = $clog2(MAX_BURST) + 1;
  localparam logic [c_cnt_w-1:0] c_max_burst = c_cnt_w'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDATA  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_last_host;   // 1 when the host received the last grant
  logic               r_owner_host;  // owner of the transaction in flight
  logic [c_cnt_w-1:0] r_burst_cnt;
  logic               r_core_gnt;
  logic               r_host_gnt;
  logic               r_core_rvalid;
  logic               r_host_rvalid;
  logic               r_mem_en;
  logic               r_mem_we;
  logic [7:0]         r_mem_addr;
  logic [7:0]         r_mem_wdata;

  logic               w_burst_ok;
  logic               w_lock_win;
  logic               w_grant_core;
  logic               w_grant_host;

  assign w_burst_ok = (r_burst_cnt < c_max_burst);
  assign w_lock_win = bus.host_req && bus.host_lock && w_burst_ok;

  // Winner selection, only meaningful in IDLE. A locked host under its burst
  // budget beats the core; otherwise the requester not granted last wins a
  // tie. Once the budget is spent the tie-break alone hands the core the
  // port, since the host was necessarily the last one granted.
  always_comb begin
    w_grant_core = 1'b0;
    w_grant_host = 1'b0;
    if (r_state == ST_IDLE) begin
      if (w_lock_win) begin
        w_grant_host = 1'b1;
      end else if (bus.core_req && bus.host_req) begin
        if (r_last_host) begin
          w_grant_core = 1'b1;
        end else begin
          w_grant_host = 1'b1;
        end
      end else if (bus.core_req) begin
        w_grant_core = 1'b1;
      end else if (bus.host_req) begin
        w_grant_host = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_last_host   <= 1'b1;
      r_owner_host  <= 1'b0;
      r_burst_cnt   <= '0;
      r_core_gnt    <= 1'b0;
      r_host_gnt    <= 1'b0;
      r_core_rvalid <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
    end else begin
      // Every registered output is a one-cycle pulse; default them low and
      // raise only the ones belonging to the state being entered.
      r_core_gnt    <= 1'b0;
      r_host_gnt    <= 1'b0;
      r_core_rvalid <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;

      case (r_state)
        ST_IDLE: begin
          if (w_grant_core || !bus.host_lock) begin
            r_burst_cnt <= '0;
          end else if (w_grant_host && w_burst_ok) begin
            r_burst_cnt <= r_burst_cnt + c_cnt_w'(1);
          end

          if (w_grant_core) begin
            r_state      <= ST_ACCESS;
            r_core_gnt   <= 1'b1;
            r_owner_host <= 1'b0;
            r_last_host  <= 1'b0;
            r_mem_en     <= 1'b1;
            r_mem_we     <= bus.core_we;
            r_mem_addr   <= bus.core_addr;
            r_mem_wdata  <= bus.core_wdata;
          end else if (w_grant_host) begin
            r_state      <= ST_ACCESS;
            r_host_gnt   <= 1'b1;
            r_owner_host <= 1'b1;
            r_last_host  <= 1'b1;
            r_mem_en     <= 1'b1;
            r_mem_we     <= bus.host_we;
            r_mem_addr   <= bus.host_addr;
            r_mem_wdata  <= bus.host_wdata;
          end
        end

        ST_ACCESS: begin
          if (r_mem_we) begin
            r_state <= ST_IDLE;
          end else begin
            r_state       <= ST_RDATA;
            r_core_rvalid <= !r_owner_host;
            r_host_rvalid <= r_owner_host;
          end
        end

        ST_RDATA: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.core_gnt    = r_core_gnt;
  assign bus.host_gnt    = r_host_gnt;
  assign bus.core_rvalid = r_core_rvalid;
  assign bus.host_rvalid = r_host_rvalid;
  // The memory returns data during RDATA itself, so read data is steered
  // straight through, gated by the registered rvalid of the owner.
  assign bus.core_rdata  = r_core_rvalid ? bus.mem_rdata : 8'h00;
  assign bus.host_rdata  = r_host_rvalid ? bus.mem_rdata : 8'h00;
  assign bus.mem_en      = r_mem_en;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter with a
//               one-cycle-latency memory model behind the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic clock;
  logic reset;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_BURST(16)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous memory: read data appears the cycle after a read command.
  logic [7:0] mem_array [256];
  always @(posedge clock) begin
    if (bus.mem_en && bus.mem_we) mem_array[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= (bus.mem_en && !bus.mem_we) ? mem_array[bus.mem_addr] : 8'h00;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Packs every DUT output so quiescence can be checked in one comparison.
  function automatic logic [31:0] outs();
    return {bus.core_gnt, bus.core_rvalid, bus.core_rdata,
            bus.host_gnt, bus.host_rvalid, bus.host_rdata,
            bus.mem_en, bus.mem_we, bus.mem_addr != 8'h00, bus.mem_wdata != 8'h00};
  endfunction

  int seq [64];          // grant order: 1 = core, 2 = host
  int n_got;
  int n_multi;
  int rd_bad;
  logic [7:0] exp_core_rd;
  logic [7:0] exp_host_rd;

  task automatic collect(input int n, input int budget);
    n_got   = 0;
    n_multi = 0;
    rd_bad  = 0;
    for (int c = 0; c < budget && n_got < n; c++) begin
      tick();
      if (bus.core_gnt && bus.host_gnt) n_multi++;
      if (bus.core_rvalid && bus.host_rvalid) n_multi++;
      if (bus.core_rvalid && bus.core_rdata !== exp_core_rd) rd_bad++;
      if (bus.host_rvalid && bus.host_rdata !== exp_host_rd) rd_bad++;
      if (bus.core_gnt) begin
        seq[n_got] = 1;
        n_got++;
      end else if (bus.host_gnt) begin
        seq[n_got] = 2;
        n_got++;
      end
    end
    check("collect_count", 32'(n_got), 32'(n));
    check("one_hot", 32'(n_multi), 32'd0);
    check("rdata_during_collect", 32'(rd_bad), 32'd0);
  endtask

  task automatic idle_inputs();
    bus.core_req   = 1'b0;
    bus.core_we    = 1'b0;
    bus.core_addr  = 8'h00;
    bus.core_wdata = 8'h00;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_lock  = 1'b0;
    bus.host_addr  = 8'h00;
    bus.host_wdata = 8'h00;
  endtask

  task automatic host_cmd(input logic we, input logic lock, input logic [7:0] addr,
                          input logic [7:0] wdata);
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_lock  = lock;
    bus.host_addr  = addr;
    bus.host_wdata = wdata;
  endtask

  task automatic core_cmd(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    bus.core_req   = 1'b1;
    bus.core_we    = we;
    bus.core_addr  = addr;
    bus.core_wdata = wdata;
  endtask

  int cnt;

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (3) tick();
    check("reset_outputs", outs(), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_outputs", outs(), 32'd0);

    // Host write 0x20 <= 0xA5.
    host_cmd(1'b1, 1'b0, 8'h20, 8'hA5);
    tick();
    check("hw_host_gnt", 32'(bus.host_gnt), 32'd1);
    check("hw_core_gnt", 32'(bus.core_gnt), 32'd0);
    check("hw_mem_en", 32'(bus.mem_en), 32'd1);
    check("hw_mem_we", 32'(bus.mem_we), 32'd1);
    check("hw_mem_addr", 32'(bus.mem_addr), 32'h20);
    check("hw_mem_wdata", 32'(bus.mem_wdata), 32'hA5);
    idle_inputs();
    tick();
    check("hw_after", outs(), 32'd0);

    // Host write 0x05 <= 0x0B, issued straight from the IDLE after a write.
    host_cmd(1'b1, 1'b0, 8'h05, 8'h0B);
    tick();
    check("hw2_host_gnt", 32'(bus.host_gnt), 32'd1);
    idle_inputs();
    tick();

    // Core read 0x05.
    core_cmd(1'b0, 8'h05, 8'h00);
    tick();
    check("cr_core_gnt", 32'(bus.core_gnt), 32'd1);
    check("cr_mem", {bus.mem_en, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 8'h05});
    check("cr_host_quiet", {bus.host_gnt, bus.host_rvalid, bus.host_rdata}, 32'd0);
    idle_inputs();
    tick();
    check("cr_rvalid", {bus.core_rvalid, bus.core_rdata}, {1'b1, 8'h0B});
    check("cr_host_rvalid", {bus.host_rvalid, bus.host_rdata}, 32'd0);
    check("cr_mem_idle", 32'(bus.mem_en), 32'd0);
    tick();
    check("cr_after", outs(), 32'd0);

    // Host read 0x20; core request arrives while the host is in ACCESS.
    host_cmd(1'b0, 1'b0, 8'h20, 8'h00);
    tick();
    check("hr_host_gnt", 32'(bus.host_gnt), 32'd1);
    idle_inputs();
    core_cmd(1'b0, 8'h05, 8'h00);
    tick();
    check("hr_rvalid", {bus.host_rvalid, bus.host_rdata}, {1'b1, 8'hA5});
    check("hr_holdoff_rdata", {bus.core_gnt, bus.core_rvalid}, 32'd0);
    tick();
    check("hr_holdoff_idle", 32'(bus.core_gnt), 32'd0);
    tick();
    check("hr_core_gnt", 32'(bus.core_gnt), 32'd1);
    idle_inputs();
    tick();
    check("hr_core_rdata", {bus.core_rvalid, bus.core_rdata}, {1'b1, 8'h0B});
    tick();

    // Reset during RDATA of a core read.
    core_cmd(1'b0, 8'h05, 8'h00);
    tick();
    idle_inputs();
    tick();
    check("rst_pre_rvalid", 32'(bus.core_rvalid), 32'd1);
    reset = 1'b1;
    tick();
    check("rst_outputs", outs(), 32'd0);
    reset = 1'b0;
    // Both read continuously; last-granted was core but reset makes it host.
    core_cmd(1'b0, 8'h05, 8'h00);
    host_cmd(1'b0, 1'b0, 8'h20, 8'h00);
    exp_core_rd = 8'h0B;
    exp_host_rd = 8'hA5;
    collect(4, 40);
    check("rr_0", 32'(seq[0]), 32'd1);
    check("rr_1", 32'(seq[1]), 32'd2);
    check("rr_2", 32'(seq[2]), 32'd1);
    check("rr_3", 32'(seq[3]), 32'd2);

    // Locked host bursts against a continuously requesting core.
    idle_inputs();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    host_cmd(1'b1, 1'b1, 8'h30, 8'h11);
    core_cmd(1'b0, 8'h05, 8'h00);
    collect(34, 400);
    cnt = 0;
    for (int i = 0; i < 16; i++) if (seq[i] == 2) cnt++;
    check("lock_first_burst", 32'(cnt), 32'd16);
    check("lock_core_17th", 32'(seq[16]), 32'd1);
    cnt = 0;
    for (int i = 17; i < 33; i++) if (seq[i] == 2) cnt++;
    check("lock_second_burst", 32'(cnt), 32'd16);
    check("lock_core_34th", 32'(seq[33]), 32'd1);

    // Locked host alone keeps the port back-to-back beyond MAX_BURST.
    idle_inputs();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    host_cmd(1'b1, 1'b1, 8'h31, 8'h22);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.host_gnt) cnt++;
    end
    check("lock_no_gaps", 32'(cnt), 32'd20);

    idle_inputs();
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
